// File: rtl/serializer_pkg.sv
// Shared definitions for the parallel-to-serial converter: state encoding,
// counter sizing and word-length decoding.
package serializer_pkg;

  // Legacy-compatible state encoding.
  typedef logic [1:0] state_t;

  localparam state_t IDLE_S   = 2'd0;
  localparam state_t WORK_S   = 2'd1;
  localparam state_t PARITY_S = 2'd2;

  // One bit beyond the data_mod_i width lets the full bus width be represented.
  localparam int unsigned CNT_EXTRA_BITS = 1;

  // Width of the bits-left counter for a given bus width.
  function automatic int unsigned cnt_width(input int unsigned bus_width);
    return $clog2(bus_width) + CNT_EXTRA_BITS;
  endfunction

  // A modifier of zero selects the whole bus.
  function automatic int unsigned mod_to_len(input int unsigned mod,
                                             input int unsigned bus_width);
    return (mod == 0) ? bus_width : mod;
  endfunction

endpackage

// File: rtl/serializer.sv
// Parallel-to-serial converter, MSB first, with a per-bit valid strobe.
// A word is taken when data_val_i is high and busy_o is low; its first bit is
// on ser_data_o the following cycle. busy_o drops during the final bit, so a
// word offered then follows with no idle gap.
// Optional build macro: SERIALIZER_PARITY_EN appends one even-parity bit after
// each word and moves back-to-back acceptance to that parity cycle.
module serializer
  import serializer_pkg::*;
#(
  parameter int unsigned DATA_BUS_WIDTH = 16,
  localparam int unsigned DATA_MOD_WIDTH = $clog2(DATA_BUS_WIDTH)
) (
  input  logic                      clk_i,
  input  logic                      srst_i,
  input  logic [DATA_BUS_WIDTH-1:0] data_i,
  input  logic [DATA_MOD_WIDTH-1:0] data_mod_i,
  input  logic                      data_val_i,
  output logic                      ser_data_o,
  output logic                      ser_data_val_o,
  output logic                      busy_o
);

  localparam int unsigned CntWidth = cnt_width(DATA_BUS_WIDTH);
  localparam int unsigned Msb      = DATA_BUS_WIDTH - 1;

  state_t                    state_q, state_d;
  logic [DATA_BUS_WIDTH-1:0] shift_q, shift_d;
  // Counts bits still to send after the one currently on the output.
  logic [CntWidth-1:0]       bits_left_q, bits_left_d;
  logic                      ser_data_q, ser_data_d;
  logic                      ser_val_q, ser_val_d;
`ifdef SERIALIZER_PARITY_EN
  logic                      parity_q, parity_d;
`endif

  logic                busy;
  logic                accept;
  logic [CntWidth-1:0] len_m1;

  assign len_m1 = CntWidth'(mod_to_len(32'(data_mod_i), DATA_BUS_WIDTH) - 1);

  // Busy while more bits (or the parity bit) remain behind the current one.
  always_comb begin
`ifdef SERIALIZER_PARITY_EN
    busy = (state_q == WORK_S);
`else
    busy = (state_q == WORK_S) && (bits_left_q != '0);
`endif
  end

  assign accept = data_val_i && !busy;

  // Next-state: load on accept, otherwise shift out and count down.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bits_left_d = bits_left_q;
    ser_data_d  = 1'b0;
    ser_val_d   = 1'b0;
`ifdef SERIALIZER_PARITY_EN
    parity_d    = parity_q;
`endif
    if (accept) begin
      // First bit goes straight to the output register; the rest wait in shift_q.
      state_d     = WORK_S;
      shift_d     = data_i << 1;
      bits_left_d = len_m1;
      ser_data_d  = data_i[Msb];
      ser_val_d   = 1'b1;
`ifdef SERIALIZER_PARITY_EN
      parity_d    = data_i[Msb];
`endif
    end else begin
      case (state_q)
        WORK_S: begin
          if (bits_left_q != '0) begin
            ser_data_d  = shift_q[Msb];
            ser_val_d   = 1'b1;
            shift_d     = shift_q << 1;
            bits_left_d = bits_left_q - CntWidth'(1);
`ifdef SERIALIZER_PARITY_EN
            parity_d    = parity_q ^ shift_q[Msb];
`endif
          end else begin
`ifdef SERIALIZER_PARITY_EN
            state_d    = PARITY_S;
            ser_data_d = parity_q;
            ser_val_d  = 1'b1;
`else
            state_d    = IDLE_S;
`endif
          end
        end
`ifdef SERIALIZER_PARITY_EN
        PARITY_S: state_d = IDLE_S;
`endif
        default: state_d = IDLE_S;
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!srst_i) begin
      state_q     <= IDLE_S;
      shift_q     <= '0;
      bits_left_q <= '0;
      ser_data_q  <= 1'b0;
      ser_val_q   <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bits_left_q <= bits_left_d;
      ser_data_q  <= ser_data_d;
      ser_val_q   <= ser_val_d;
`ifdef SERIALIZER_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  assign ser_data_o     = ser_data_q;
  assign ser_data_val_o = ser_val_q;
  assign busy_o         = busy;

endmodule

// File: tb/tb_serializer.sv
// Self-checking bench for serializer: directed steps plus random traffic,
// checked cycle by cycle against a queue-of-bits reference model.
module tb_serializer;

  localparam int unsigned W  = 16;
  localparam int unsigned MW = $clog2(W);

  logic          clk_i = 1'b0;
  logic          srst_i;
  logic [W-1:0]  data_i;
  logic [MW-1:0] data_mod_i;
  logic          data_val_i;
  logic          ser_data_o;
  logic          ser_data_val_o;
  logic          busy_o;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: bit on the line now, and the bits still to follow.
  bit cur_val;
  bit cur_bit;
  bit rest[$];

  always #5 clk_i = ~clk_i;

  serializer #(
    .DATA_BUS_WIDTH(W)
  ) dut (
    .clk_i         (clk_i),
    .srst_i        (srst_i),
    .data_i        (data_i),
    .data_mod_i    (data_mod_i),
    .data_val_i    (data_val_i),
    .ser_data_o    (ser_data_o),
    .ser_data_val_o(ser_data_val_o),
    .busy_o        (busy_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, compare just after the edge.
  task automatic step(input bit rst_n, input bit val, input logic [W-1:0] d,
                      input logic [MW-1:0] m);
    bit acc;
    int len;
    bit par;
    srst_i     = rst_n;
    data_val_i = val;
    data_i     = d;
    data_mod_i = m;
    acc = rst_n && val && (rest.size() == 0);
    @(posedge clk_i);
    #1;
    if (!rst_n) begin
      cur_val = 1'b0;
      cur_bit = 1'b0;
      rest.delete();
    end else if (acc) begin
      len = (m == 0) ? W : int'(m);
      par = 1'b0;
      rest.delete();
      for (int i = 0; i < len; i++) begin
        rest.push_back(d[W-1-i]);
        par ^= d[W-1-i];
      end
`ifdef SERIALIZER_PARITY_EN
      rest.push_back(par);
`endif
      cur_bit = rest.pop_front();
      cur_val = 1'b1;
    end else if (rest.size() != 0) begin
      cur_bit = rest.pop_front();
      cur_val = 1'b1;
    end else begin
      cur_val = 1'b0;
      cur_bit = 1'b0;
    end
    check("ser_data_val_o", 32'(ser_data_val_o), 32'(cur_val));
    check("ser_data_o", 32'(ser_data_o), 32'(cur_bit));
    check("busy_o", 32'(busy_o), 32'(rest.size() != 0));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, '0);
  endtask

  initial begin
    logic [W-1:0] cap;
    bit v;

    // Reset state.
    step(1'b0, 1'b0, '0, '0);
    step(1'b0, 1'b1, 16'hFFFF, '0);
    idle(2);

    // Full-width word, captured bit by bit and compared to the word itself.
    step(1'b1, 1'b1, 16'hA5C3, '0);
    cap = {cap[W-2:0], ser_data_o};
    for (int i = 0; i < 15; i++) begin
      step(1'b1, 1'b0, 16'h0F0F, 4'd3);
      cap = {cap[W-2:0], ser_data_o};
    end
    check("a5c3_stream", 32'(cap), 32'h0000_A5C3);
    idle(3);

    // Short words: 4 bits, then a single bit.
    step(1'b1, 1'b1, 16'hB000, 4'd4);
    idle(6);
    step(1'b1, 1'b1, 16'h8000, 4'd1);
    idle(3);

    // data_val_i held high: all-ones word, then all-zeros from the handover on.
    for (int i = 0; i < 34; i++) step(1'b1, 1'b1, (i < 16) ? 16'hFFFF : 16'h0000, '0);
    idle(36);

    // Word offered while busy is dropped.
    step(1'b1, 1'b1, 16'hC3A5, '0);
    step(1'b1, 1'b1, 16'h1234, '0);
    idle(19);

    // Reset mid-word, then a fresh word.
    step(1'b1, 1'b1, 16'hFFFF, '0);
    idle(4);
    step(1'b0, 1'b0, '0, '0);
    step(1'b1, 1'b1, 16'h5A5A, '0);
    idle(19);

    // Parity-friendly word (odd number of ones).
    step(1'b1, 1'b1, 16'h0007, '0);
    idle(19);

    // Random traffic, with occasional resets and changing inputs.
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 2) != 0);
      step(($urandom_range(0, 63) != 0), v, W'($urandom), MW'($urandom));
    end
    idle(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
